rx_frame_receiver: RTL and testbench
====================================

Name: rx_frame_receiver

Overview:
Downstream consumer of the zero-crossing demodulator. Takes one recovered bit per bit period, hunts for an 8-bit sync word, and assembles the next 16 bits into DATA_BYTE_1 (first byte) and DATA_BYTE_0 (second byte). Owns the BD control/status register (STATUS, INTFLAG, INTMASK, RXENABLE, OVERRUN) and raises int_rx_host. Sits between the demodulator and the host bus.

Parameters:
SYNC_WORD, 8'hA5, frame sync pattern, compared MSB-first.
TIMEOUT_CYCLES, 96, max G_CLK_RX cycles between bit_valid pulses in RECV before abort (3 bit periods of 32 clocks).

Ports:
G_CLK_RX  input  1  receive clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
bit_valid  input  1  one-cycle strobe from the demodulator, once per bit period.
bit_data  input  1  recovered bit; qualified by bit_valid.
ctrl_wr  input  1  host write strobe to the control register.
ctrl_wdata  input  8  host write data; bit map below.
ctrl_rdata  output  8  {3'b0, OVERRUN, STATUS, INTFLAG, INTMASK, RXENABLE}.
DATA_BYTE_0  output  8  second received byte of the last complete frame.
DATA_BYTE_1  output  8  first received byte of the last complete frame.
int_rx_host  output  1  interrupt = INTFLAG & INTMASK (combinational from registers).

Behaviour:
- Reset (reset=0, asynchronous): state=HUNT; sync shifter, data shifter, bit_cnt and timeout counter = 0; DATA_BYTE_0/1 = 8'h00; RXENABLE, INTMASK, INTFLAG, STATUS and OVERRUN = 0; int_rx_host=0.
- Control write (ctrl_wr=1): RXENABLE<=wdata[0]; INTMASK<=wdata[1]; wdata[2]=1 clears INTFLAG; wdata[4]=1 clears OVERRUN; wdata[3] is ignored (STATUS is read-only). A clear and a frame-complete set in the same cycle: the set wins.
- RXENABLE=0: FSM is forced to HUNT, STATUS=0, and bit_valid is ignored. DATA_BYTE_0/1 hold their values. Deasserting RXENABLE mid-frame discards the partial frame; no flag is set.
- HUNT: on each bit_valid, sync <= {sync[6:0], bit_data}. If the new value equals SYNC_WORD, go to RECV on that edge: bit_cnt=0, timeout=0, STATUS=1.
- RECV: on each bit_valid, shift <= {shift[14:0], bit_data}; bit_cnt increments and timeout resets to 0.
  - On the 16th bit, on the same edge: DATA_BYTE_1 <= shift[14:7] with the incoming bit folded in (i.e. bits 1-8 of the payload), DATA_BYTE_0 <= bits 9-16; INTFLAG<=1; OVERRUN<=1 if INTFLAG was already 1; STATUS<=0; sync<=0; return to HUNT.
  - Outputs are visible the cycle after the edge that samples the 16th bit.
- Timeout: in RECV, the counter increments every cycle without bit_valid. On reaching TIMEOUT_CYCLES: abort to HUNT, STATUS=0, sync=0, data outputs and flags unchanged.
- Sync pattern bits inside the payload are not re-detected (the sync shifter is frozen in RECV).
- Back-to-back frames: the sync of the next frame may start on the bit_valid immediately after the 16th payload bit.
- bit_cnt: 4-bit width plus a done compare; no wrap into a second frame.

Test Plan:
1. Reset, write ctrl 8'h03, send A5 then 8'h3C, 8'hC3 -> DATA_BYTE_1=8'h3C, DATA_BYTE_0=8'hC3, ctrl_rdata=8'h07, int_rx_host=1 one cycle after the last bit.
2. Write 8'h07 (clear INTFLAG) -> int_rx_host=0, ctrl_rdata=8'h03. Repeat with INTMASK=0 -> INTFLAG=1 but int_rx_host stays 0.
3. Two frames without clearing INTFLAG -> second frame's data latched, ctrl_rdata bit4 (OVERRUN)=1. Write 8'h10 -> OVERRUN=0.
4. Send A5 then 9 payload bits, then silence for 96 cycles -> STATUS drops to 0, data bytes unchanged, INTFLAG=0. A following full frame is received correctly.
5. Mid-frame write 8'h02 (RXENABLE=0) -> STATUS=0 immediately. Further bits are ignored. Re-enable and send a full frame -> correct bytes.
6. Assert reset asynchronously mid-RECV, between clock edges -> all outputs 0 at once. A noise stream 8'h5A, 8'hA4 with no A5 -> STATUS never rises.

Source files
------------

// File: rtl/rx_frame_receiver.sv
// rtl/rx_frame_receiver.sv - sync-word hunter and two-byte frame assembler with host control register
module rx_frame_receiver #(
    parameter logic [7:0] SYNC_WORD      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 96
) (
    input  logic       G_CLK_RX,
    input  logic       reset,
    input  logic       bit_valid,
    input  logic       bit_data,
    input  logic       ctrl_wr,
    input  logic [7:0] ctrl_wdata,
    output logic [7:0] ctrl_rdata,
    output logic [7:0] DATA_BYTE_0,
    output logic [7:0] DATA_BYTE_1,
    output logic       int_rx_host
);

    typedef enum logic {HUNT, RECV} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_sync;
    logic [14:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic [6:0]  r_timeout;
    logic        r_rxenable, r_intmask, r_intflag, r_overrun;
    logic [7:0]  r_byte0, r_byte1;

    logic [7:0]  w_sync_next;
    logic        w_disable, w_bit, w_hit, w_done, w_tmo;
    logic        w_unused_wdata;

    assign w_sync_next    = {r_sync[6:0], bit_data};
    assign w_disable      = !r_rxenable || (ctrl_wr && !ctrl_wdata[0]);
    assign w_bit          = r_rxenable && bit_valid;
    assign w_hit          = (r_state == HUNT) && w_bit && (w_sync_next == SYNC_WORD);
    assign w_done         = (r_state == RECV) && w_bit && (r_bit_cnt == 4'd15);
    assign w_tmo          = (r_state == RECV) && !bit_valid && (r_timeout == 7'(TIMEOUT_CYCLES - 1));
    assign w_unused_wdata = &{ctrl_wdata[7:5], ctrl_wdata[3]};

    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) r_state <= HUNT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_disable) begin
            w_state_next = HUNT;
        end else begin
            case (r_state)
                HUNT:    if (w_hit) w_state_next = RECV;
                RECV:    if (w_done || w_tmo) w_state_next = HUNT;
                default: w_state_next = HUNT;
            endcase
        end
    end

    // The sync shifter is frozen while in RECV so payload bits never re-trigger a hunt.
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            r_sync    <= 8'h00;
            r_shift   <= 15'h0000;
            r_bit_cnt <= 4'd0;
            r_timeout <= 7'd0;
            r_byte0   <= 8'h00;
            r_byte1   <= 8'h00;
        end else if (!r_rxenable) begin
            r_sync <= 8'h00;
        end else if (r_state == HUNT) begin
            if (bit_valid) begin
                r_sync <= w_sync_next;
                if (w_sync_next == SYNC_WORD) begin
                    r_bit_cnt <= 4'd0;
                    r_timeout <= 7'd0;
                end
            end
        end else if (bit_valid) begin
            r_shift   <= {r_shift[13:0], bit_data};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_timeout <= 7'd0;
            if (w_done) begin
                r_byte1 <= r_shift[14:7];
                r_byte0 <= {r_shift[6:0], bit_data};
                r_sync  <= 8'h00;
            end
        end else if (w_tmo) begin
            r_sync    <= 8'h00;
            r_timeout <= 7'd0;
        end else begin
            r_timeout <= r_timeout + 7'd1;
        end
    end

    // A frame completion outranks a host clear landing on the same edge.
    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            r_rxenable <= 1'b0;
            r_intmask  <= 1'b0;
            r_intflag  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                r_rxenable <= ctrl_wdata[0];
                r_intmask  <= ctrl_wdata[1];
            end
            if (w_done) begin
                r_intflag <= 1'b1;
                if (r_intflag) r_overrun <= 1'b1;
                else if (ctrl_wr && ctrl_wdata[4]) r_overrun <= 1'b0;
            end else begin
                if (ctrl_wr && ctrl_wdata[2]) r_intflag <= 1'b0;
                if (ctrl_wr && ctrl_wdata[4]) r_overrun <= 1'b0;
            end
        end
    end

    assign ctrl_rdata  = {3'b000, r_overrun, (r_state == RECV), r_intflag, r_intmask, r_rxenable};
    assign DATA_BYTE_0 = r_byte0;
    assign DATA_BYTE_1 = r_byte1;
    assign int_rx_host = r_intflag & r_intmask;

endmodule

// File: tb/tb_rx_frame_receiver.sv
// tb/tb_rx_frame_receiver.sv - scoreboard bench for rx_frame_receiver
module tb_rx_frame_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       ctrl_wr = 1'b0;
    logic [7:0] ctrl_wdata = 8'h00;
    logic [7:0] ctrl_rdata, DATA_BYTE_0, DATA_BYTE_1;
    logic       int_rx_host;

    int n_checks = 0;
    int n_fails  = 0;
    logic [24:0] exp_q[$];

    rx_frame_receiver dut (
        .G_CLK_RX    (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .ctrl_wr     (ctrl_wr),
        .ctrl_wdata  (ctrl_wdata),
        .ctrl_rdata  (ctrl_rdata),
        .DATA_BYTE_0 (DATA_BYTE_0),
        .DATA_BYTE_1 (DATA_BYTE_1),
        .int_rx_host (int_rx_host)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_data  = b;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    task automatic wr(input logic [7:0] v);
        @(negedge clk);
        ctrl_wr    = 1'b1;
        ctrl_wdata = v;
        @(negedge clk);
        ctrl_wr    = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d1, input logic [7:0] d0,
                                input logic [7:0] rd, input logic intr);
        exp_q.push_back({d1, d0, rd, intr});
    endtask

    task automatic frame(input logic [7:0] d1, input logic [7:0] d0,
                         input logic [7:0] rd, input logic intr);
        send_bits(8'hA5, 8);
        send_bits(d1, 8);
        send_bits(d0, 7);
        expect_frame(d1, d0, rd, intr);
        send_bit(d0[0]);
    endtask

    // Monitor: every RECV exit (STATUS falling) must match the next queued expectation.
    initial begin : monitor
        logic        prev_status;
        logic [24:0] e;
        prev_status = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_status = 1'b0;
            end else begin
                if (prev_status && !ctrl_rdata[3]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL unexpected_frame_end: rdata %h with no expectation", ctrl_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("mon_byte1", DATA_BYTE_1, e[24:17]);
                        check("mon_byte0", DATA_BYTE_0, e[16:9]);
                        check("mon_rdata", ctrl_rdata, e[8:1]);
                        check("mon_int", {7'b0, int_rx_host}, {7'b0, e[0]});
                    end
                end
                prev_status = ctrl_rdata[3];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rdata", ctrl_rdata, 8'h00);
        check("rst_byte0", DATA_BYTE_0, 8'h00);
        check("rst_byte1", DATA_BYTE_1, 8'h00);
        check("rst_int", {7'b0, int_rx_host}, 8'h00);
        reset = 1'b1;

        // 1: basic frame
        wr(8'h03);
        check("en_rdata", ctrl_rdata, 8'h03);
        frame(8'h3C, 8'hC3, 8'h07, 1'b1);

        // 2: clear flag, then masked frame
        wr(8'h07);
        check("clr_rdata", ctrl_rdata, 8'h03);
        check("clr_int", {7'b0, int_rx_host}, 8'h00);
        wr(8'h05);
        check("nomask_rdata", ctrl_rdata, 8'h01);
        frame(8'h12, 8'h34, 8'h05, 1'b0);

        // 3: overrun, with sync pattern inside payload
        wr(8'h07);
        check("clr2_rdata", ctrl_rdata, 8'h03);
        frame(8'h55, 8'hAA, 8'h07, 1'b1);
        frame(8'hA5, 8'h5A, 8'h17, 1'b1);
        wr(8'h10);
        check("ovr_clr_rdata", ctrl_rdata, 8'h04);
        wr(8'h07);
        check("reen_rdata", ctrl_rdata, 8'h03);

        // 4: timeout after 9 payload bits
        send_bits(8'hA5, 8);
        send_bits(8'hB3, 8);
        send_bit(1'b1);
        check("recv_rdata", ctrl_rdata, 8'h0B);
        expect_frame(8'hA5, 8'h5A, 8'h03, 1'b0);
        repeat (80) @(negedge clk);
        check("pre_tmo_rdata", ctrl_rdata, 8'h0B);
        repeat (30) @(negedge clk);
        check("post_tmo_rdata", ctrl_rdata, 8'h03);
        frame(8'h96, 8'h69, 8'h07, 1'b1);
        wr(8'h07);

        // 5: disable mid-frame
        send_bits(8'hA5, 8);
        send_bits(8'hF0, 4);
        check("recv2_rdata", ctrl_rdata, 8'h0B);
        expect_frame(8'h96, 8'h69, 8'h02, 1'b0);
        wr(8'h02);
        check("dis_rdata", ctrl_rdata, 8'h02);
        send_bits(8'hA5, 8);
        send_bits(8'h01, 8);
        send_bits(8'h02, 8);
        check("dis_hold_rdata", ctrl_rdata, 8'h02);
        check("dis_hold_b1", DATA_BYTE_1, 8'h96);
        check("dis_hold_b0", DATA_BYTE_0, 8'h69);
        wr(8'h03);
        check("reen2_rdata", ctrl_rdata, 8'h03);
        frame(8'h11, 8'hEE, 8'h07, 1'b1);

        // 6: async reset mid-RECV, then noise
        send_bits(8'hA5, 8);
        send_bits(8'hC0, 5);
        #2 reset = 1'b0;
        #1;
        check("arst_rdata", ctrl_rdata, 8'h00);
        check("arst_byte0", DATA_BYTE_0, 8'h00);
        check("arst_byte1", DATA_BYTE_1, 8'h00);
        check("arst_int", {7'b0, int_rx_host}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr(8'h03);
        for (int k = 0; k < 16; k++) begin
            logic [15:0] noise;
            noise = 16'h5AA4;
            send_bit(noise[15-k]);
            check("noise_status", {7'b0, ctrl_rdata[3]}, 8'h00);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
